// File: rtl/plot_move_sequencer.sv
// plot_move_sequencer
// Coordinated X/Y stepper and pen-servo move controller. Accepts one relative
// move at a time, sets the pen, optionally waits for the servo to settle, then
// emits DDA-interpolated step pulses on both axes, one tick every STEP_PERIOD
// clocks, so lines of any slope come out straight.
//
// Build option: define PEN_SETTLE_EN to include the pen settle wait
// (SETTLE_CYCLES clocks after a pen change). Without it a pen change adds no
// cycles and no settle counter exists.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-low
//   cmd_valid/ready  command handshake; ready only while idle
//   cmd_dx, cmd_dy   signed relative step counts
//   cmd_pen          pen state for the move (1 = down)
//   abort            ends the active move at the next cycle
//   step_x, step_y   step pulses, PULSE_WIDTH clocks high
//   dir_x, dir_y     direction (1 = positive)
//   pen_down         servo command
//   busy             high from the cycle after acceptance through DONE
//   done             one-cycle completion pulse
//   pos_x, pos_y     signed absolute position, wraps mod 2^W
//
// state  | meaning
// IDLE   | ready for a command
// PEN    | pen output updated; decide settle / tick / done
// SETTLE | waiting for the servo after a pen change
// TICK   | issuing n step ticks
// DONE   | one-cycle completion pulse
module plot_move_sequencer #(
  parameter int W             = 16,
  parameter int STEP_PERIOD   = 20000,
  parameter int PULSE_WIDTH   = 100,
  parameter int SETTLE_CYCLES = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic signed [W-1:0] cmd_dx,
  input  logic signed [W-1:0] cmd_dy,
  input  logic                cmd_pen,
  input  logic                abort,
  output logic                step_x,
  output logic                step_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                pen_down,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] pos_x,
  output logic signed [W-1:0] pos_y
);

  localparam int CW = $clog2(STEP_PERIOD);
  localparam logic [CW-1:0] CNT_LOAD      = CW'(STEP_PERIOD - 1);
  localparam logic [CW-1:0] CNT_PULSE_END = CW'(STEP_PERIOD - PULSE_WIDTH);

`ifdef PEN_SETTLE_EN
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PEN, SETTLE, TICK, DONE} state_t;
  logic [SW-1:0] settle_cnt;
  logic          pen_chg;
`else
  typedef enum logic [2:0] {IDLE, PEN, TICK, DONE} state_t;
  // SETTLE_CYCLES has no effect in this build.
  logic settle_unused;
  assign settle_unused = (SETTLE_CYCLES != 0);
`endif

  state_t        state;
  logic [W-1:0]  ax, ay, n, ticks_left;
  logic [W:0]    acc_x, acc_y;
  logic [CW-1:0] cnt;

  logic [W-1:0]  mag_x, mag_y, mag_max;
  logic [W:0]    n_ext, sum_x, sum_y;
  logic          hit_x, hit_y;
  logic          start_tick, enter_done;

  // Magnitudes as unsigned W bits, so the most negative value maps to 2^(W-1).
  always_comb begin
    mag_x   = cmd_dx[W-1] ? W'(-cmd_dx) : W'(cmd_dx);
    mag_y   = cmd_dy[W-1] ? W'(-cmd_dy) : W'(cmd_dy);
    mag_max = (mag_x >= mag_y) ? mag_x : mag_y;
  end

  // DDA step decision for the tick about to start. acc < n, so the sum
  // never exceeds 2n and fits in W+1 bits.
  always_comb begin
    n_ext = {1'b0, n};
    sum_x = acc_x + {1'b0, ax};
    sum_y = acc_y + {1'b0, ay};
    hit_x = (sum_x >= n_ext);
    hit_y = (sum_y >= n_ext);
  end

  always_comb begin
    start_tick = 1'b0;
    enter_done = 1'b0;
    case (state)
      PEN: begin
`ifdef PEN_SETTLE_EN
        start_tick = !abort && !pen_chg && (n != '0);
        enter_done = abort || (!pen_chg && (n == '0));
`else
        start_tick = !abort && (n != '0);
        enter_done = abort || (n == '0);
`endif
      end
`ifdef PEN_SETTLE_EN
      SETTLE: begin
        start_tick = !abort && (settle_cnt == '0) && (n != '0);
        enter_done = abort || ((settle_cnt == '0) && (n == '0));
      end
`endif
      TICK: begin
        start_tick = !abort && (cnt == '0) && (ticks_left != '0);
        enter_done = abort || ((cnt == '0) && (ticks_left == '0));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_x     <= 1'b0;
      step_y     <= 1'b0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      pen_down   <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      ax         <= '0;
      ay         <= '0;
      n          <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      ticks_left <= '0;
      cnt        <= '0;
`ifdef PEN_SETTLE_EN
      settle_cnt <= '0;
      pen_chg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ax    <= mag_x;
            ay    <= mag_y;
            n     <= mag_max;
            acc_x <= {1'b0, mag_max >> 1};
            acc_y <= {1'b0, mag_max >> 1};
            if (cmd_dx != '0) dir_x <= ~cmd_dx[W-1];
            if (cmd_dy != '0) dir_y <= ~cmd_dy[W-1];
            pen_down  <= cmd_pen;
`ifdef PEN_SETTLE_EN
            pen_chg   <= (cmd_pen != pen_down);
`endif
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= PEN;
          end
        end
        PEN: begin
`ifdef PEN_SETTLE_EN
          if (!abort && pen_chg) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
`endif
        end
`ifdef PEN_SETTLE_EN
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
        end
`endif
        TICK: begin
          if (cnt == CNT_PULSE_END) begin
            step_x <= 1'b0;
            step_y <= 1'b0;
          end
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_done) begin
        state  <= DONE;
        done   <= 1'b1;
        step_x <= 1'b0;
        step_y <= 1'b0;
      end

      // Register the tick's pulses and position so they appear on its first cycle.
      if (start_tick) begin
        state      <= TICK;
        cnt        <= CNT_LOAD;
        ticks_left <= (state == TICK) ? ticks_left - W'(1) : n - W'(1);
        step_x     <= hit_x;
        step_y     <= hit_y;
        acc_x      <= hit_x ? sum_x - n_ext : sum_x;
        acc_y      <= hit_y ? sum_y - n_ext : sum_y;
        if (hit_x) pos_x <= dir_x ? pos_x + W'(1) : pos_x - W'(1);
        if (hit_y) pos_y <= dir_y ? pos_y + W'(1) : pos_y - W'(1);
      end
    end
  end

endmodule

// File: tb/tb_plot_move_sequencer.sv
// Directed bench for plot_move_sequencer with STEP_PERIOD=10, PULSE_WIDTH=2,
// SETTLE_CYCLES=50, W=16. Each move is captured cycle by cycle relative to
// its acceptance cycle T (bit i of a capture vector = value during T+i).
module tb_plot_move_sequencer;

  logic               clock;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [15:0] cmd_dx;
  logic signed [15:0] cmd_dy;
  logic               cmd_pen;
  logic               abort;
  logic               step_x, step_y, dir_x, dir_y, pen_down, busy, done;
  logic signed [15:0] pos_x, pos_y;

  int checks = 0;
  int passed = 0;

  logic [127:0] sx_v, sy_v, dn_v, rdy_v, bsy_v, pen_v;

`ifdef PEN_SETTLE_EN
  localparam int SETTLE_DLY = 50;
`else
  localparam int SETTLE_DLY = 0;
`endif

  plot_move_sequencer #(
    .W(16), .STEP_PERIOD(10), .PULSE_WIDTH(2), .SETTLE_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_pen(cmd_pen), .abort(abort),
    .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
    .pen_down(pen_down), .busy(busy), .done(done),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected pulse mask: tick k starts at s+10k, pulse is 2 cycles long.
  function automatic logic [127:0] tick_mask(input int s, input int nt, input logic [15:0] ticks);
    logic [127:0] m;
    m = '0;
    for (int k = 0; k < nt; k++)
      if (ticks[k]) begin
        m[s + 10*k]     = 1'b1;
        m[s + 10*k + 1] = 1'b1;
      end
    return m;
  endfunction

  function automatic logic [127:0] bit_at(input int i);
    logic [127:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic sample(input int i);
    sx_v[i]  = step_x;
    sy_v[i]  = step_y;
    dn_v[i]  = done;
    rdy_v[i] = cmd_ready;
    bsy_v[i] = busy;
    pen_v[i] = pen_down;
  endtask

  // Called #1 after a rising edge with the DUT idle; that cycle is T.
  task automatic run_move(input logic signed [15:0] dx, input logic signed [15:0] dy,
                          input logic pen, input int ncyc, input int abort_at,
                          input int valid_until);
    sx_v = '0; sy_v = '0; dn_v = '0; rdy_v = '0; bsy_v = '0; pen_v = '0;
    cmd_dx = dx; cmd_dy = dy; cmd_pen = pen; cmd_valid = 1'b1;
    sample(0);
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clock); #1;
      if (i == valid_until) cmd_valid = 1'b0;
      abort = (i == abort_at);
      sample(i);
    end
    abort = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready got %b want 1", cmd_ready); else passed++;
    checks++; if ({busy, done, step_x, step_y} !== 4'b0) $display("FAIL reset busy/done/steps got %b want 0000", {busy, done, step_x, step_y}); else passed++;
    checks++; if ({dir_x, dir_y, pen_down} !== 3'b0) $display("FAIL reset dir/pen got %b want 000", {dir_x, dir_y, pen_down}); else passed++;
    checks++; if ({pos_x, pos_y} !== 32'h0) $display("FAIL reset pos got %0d,%0d want 0,0", pos_x, pos_y); else passed++;
  endtask

  task automatic test_line;
    run_move(16'sd4, 16'sd2, 1'b0, 44, 0, 1);
    checks++; if (sx_v !== tick_mask(2, 4, 16'hF)) $display("FAIL line step_x got %h want %h", sx_v, tick_mask(2, 4, 16'hF)); else passed++;
    checks++; if (sy_v !== tick_mask(2, 4, 16'h5)) $display("FAIL line step_y got %h want %h", sy_v, tick_mask(2, 4, 16'h5)); else passed++;
    checks++; if (dn_v !== bit_at(42)) $display("FAIL line done got %h want %h", dn_v, bit_at(42)); else passed++;
    checks++; if ({bsy_v[43:42], bsy_v[1:0]} !== 4'b0110) $display("FAIL line busy edges got %b want 0110", {bsy_v[43:42], bsy_v[1:0]}); else passed++;
    checks++; if (rdy_v[43:42] !== 2'b10) $display("FAIL line cmd_ready return got %b want 10", rdy_v[43:42]); else passed++;
    checks++; if (pos_x !== 16'sd4 || pos_y !== 16'sd2) $display("FAIL line pos got %0d,%0d want 4,2", pos_x, pos_y); else passed++;
    checks++; if ({dir_x, dir_y} !== 2'b11) $display("FAIL line dir got %b want 11", {dir_x, dir_y}); else passed++;
  endtask

  task automatic test_slope;
    run_move(-16'sd3, 16'sd5, 1'b0, 54, 0, 1);
    checks++; if ({dir_x, dir_y} !== 2'b01) $display("FAIL slope dir got %b want 01", {dir_x, dir_y}); else passed++;
    checks++; if (sx_v !== tick_mask(2, 5, 16'h15)) $display("FAIL slope step_x got %h want %h", sx_v, tick_mask(2, 5, 16'h15)); else passed++;
    checks++; if (sy_v !== tick_mask(2, 5, 16'h1F)) $display("FAIL slope step_y got %h want %h", sy_v, tick_mask(2, 5, 16'h1F)); else passed++;
    checks++; if (dn_v !== bit_at(52)) $display("FAIL slope done got %h want %h", dn_v, bit_at(52)); else passed++;
    checks++; if (pos_x !== 16'sd1 || pos_y !== 16'sd7) $display("FAIL slope pos got %0d,%0d want 1,7", pos_x, pos_y); else passed++;
  endtask

  task automatic test_pen_settle;
    run_move(16'sd1, 16'sd0, 1'b1, SETTLE_DLY + 14, 0, 1);
    checks++; if (pen_v[1:0] !== 2'b10) $display("FAIL pen pen_down T..T+1 got %b want 10", pen_v[1:0]); else passed++;
    checks++; if (sx_v !== tick_mask(SETTLE_DLY + 2, 1, 16'h1)) $display("FAIL pen step_x got %h want %h", sx_v, tick_mask(SETTLE_DLY + 2, 1, 16'h1)); else passed++;
    checks++; if (dn_v !== bit_at(SETTLE_DLY + 12)) $display("FAIL pen done got %h want %h", dn_v, bit_at(SETTLE_DLY + 12)); else passed++;
    checks++; if (sy_v !== 128'h0 || dir_y !== 1'b1) $display("FAIL pen y idle got step %h dir %b want 0 dir 1", sy_v, dir_y); else passed++;
    checks++; if (pos_x !== 16'sd2 || pos_y !== 16'sd7) $display("FAIL pen pos got %0d,%0d want 2,7", pos_x, pos_y); else passed++;
  endtask

  task automatic test_abort;
    run_move(16'sd6, 16'sd0, 1'b1, 16, 13, 1);
    checks++; if (sx_v !== tick_mask(2, 2, 16'h3)) $display("FAIL abort step_x got %h want %h", sx_v, tick_mask(2, 2, 16'h3)); else passed++;
    checks++; if (dn_v !== bit_at(14)) $display("FAIL abort done got %h want %h", dn_v, bit_at(14)); else passed++;
    checks++; if (rdy_v[15:14] !== 2'b10) $display("FAIL abort cmd_ready got %b want 10", rdy_v[15:14]); else passed++;
    checks++; if (pos_x !== 16'sd4 || pen_down !== 1'b1) $display("FAIL abort pos_x/pen got %0d/%b want 4/1", pos_x, pen_down); else passed++;
  endtask

  task automatic test_reset_mid_move;
    run_move(16'sd20, 16'sd0, 1'b1, 15, 0, 1);
    checks++; if (pos_x !== 16'sd6 || busy !== 1'b1) $display("FAIL midmove pre-reset pos_x/busy got %0d/%b want 6/1", pos_x, busy); else passed++;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    checks++; if ({cmd_ready, busy, done, step_x, step_y} !== 5'b10000) $display("FAIL midmove ctrl got %b want 10000", {cmd_ready, busy, done, step_x, step_y}); else passed++;
    checks++; if ({dir_x, dir_y, pen_down} !== 3'b0 || {pos_x, pos_y} !== 32'h0) $display("FAIL midmove dir/pen/pos got %b %0d,%0d want 000 0,0", {dir_x, dir_y, pen_down}, pos_x, pos_y); else passed++;
    @(posedge clock); #1;
    checks++; if ({cmd_ready, busy, step_x} !== 3'b100) $display("FAIL midmove stays idle got %b want 100", {cmd_ready, busy, step_x}); else passed++;
  endtask

  task automatic test_back_to_back;
    run_move(16'sd0, 16'sd0, 1'b0, 6, 0, 5);
    checks++; if (dn_v !== (bit_at(2) | bit_at(5))) $display("FAIL b2b done got %h want %h", dn_v, bit_at(2) | bit_at(5)); else passed++;
    checks++; if (rdy_v[6:0] !== 7'b1001001) $display("FAIL b2b cmd_ready got %b want 1001001", rdy_v[6:0]); else passed++;
    checks++; if (bsy_v[6:0] !== 7'b0110110) $display("FAIL b2b busy got %b want 0110110", bsy_v[6:0]); else passed++;
    checks++; if (sx_v !== 128'h0 || sy_v !== 128'h0) $display("FAIL b2b steps got %h %h want 0", sx_v, sy_v); else passed++;
    checks++; if ({pos_x, pos_y} !== 32'h0) $display("FAIL b2b pos got %0d,%0d want 0,0", pos_x, pos_y); else passed++;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_dx = '0; cmd_dy = '0; cmd_pen = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    test_reset;
    test_line;
    test_slope;
    test_pen_settle;
    test_abort;
    test_reset_mid_move;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
